// File: rtl/h264_pkg.sv
// rtl/h264_pkg.sv - shared state type, widths and alignment helper for the stream scheduler
package h264_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_COEF, ST_STOP} state_t;

  localparam int ALIGN_BYTE = 8;
  localparam int VE_W       = 25;
  localparam int VL_W       = 5;
  localparam int OREG_W     = VE_W + VL_W;

  // Length of the stop-bit word that brings the bit position back to a byte boundary.
  function automatic logic [VL_W-1:0] align_len(input logic [2:0] pos);
    return VL_W'(ALIGN_BYTE) - {2'b00, pos};
  endfunction
endpackage

// File: rtl/h264_stream_oreg.sv
// rtl/h264_stream_oreg.sv - one-entry valid/ready output register
module h264_stream_oreg #(
  parameter int W = 30
) (
  input  logic         CLK,
  input  logic         RESETN,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_free,
  output logic         o_valid,
  output logic [W-1:0] o_data
);
  logic         r_valid;
  logic [W-1:0] r_data;

  assign o_free  = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load && o_free) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/h264_stream_scheduler.sv
// rtl/h264_stream_scheduler.sv - interleaves header and CAVLC words per MB and closes slices with an alignment word
module h264_stream_scheduler
  import h264_pkg::*;
#(
  parameter int CNTW = 24
) (
  input  logic            CLK,
  input  logic            RESETN,
  input  logic            NEWSLICE,
  input  logic            SLICEEND,
  input  logic            HVALID,
  output logic            HREADY,
  input  logic [19:0]     HVE,
  input  logic [4:0]      HVL,
  input  logic            HLAST,
  input  logic            CVALID,
  output logic            CREADY,
  input  logic [24:0]     CVE,
  input  logic [4:0]      CVL,
  input  logic            CLAST,
  output logic            OVALID,
  input  logic            OREADY,
  output logic [24:0]     OVE,
  output logic [4:0]      OVL,
  output logic            DONE,
  output logic [CNTW-1:0] BITS
);
  state_t              r_state, w_next;
  logic                r_end, r_sent;
  logic [2:0]          r_pos;
  logic [CNTW-1:0]     r_bits;
  logic                w_free, w_hacc, w_cacc, w_align, w_load, w_done;
  logic [VE_W-1:0]     w_ve;
  logic [VL_W-1:0]     w_vl;
  logic [OREG_W-1:0]   w_odata;
  logic [CNTW+5:0]     w_sum;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (HVALID) w_next = ST_HDR;
               else if (r_end) w_next = ST_STOP;
      ST_HDR:  if (w_hacc && HLAST) w_next = ST_COEF;
      ST_COEF: if (w_cacc && CLAST) w_next = r_end ? ST_STOP : ST_HDR;
      ST_STOP: if (w_done) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (NEWSLICE) w_next = ST_IDLE;
  end

  // Ready is withheld during NEWSLICE so a word is never accepted and then flushed.
  always_comb begin
    HREADY  = (r_state == ST_HDR)  && w_free && !NEWSLICE;
    CREADY  = (r_state == ST_COEF) && w_free && !NEWSLICE;
    w_hacc  = HVALID && HREADY;
    w_cacc  = CVALID && CREADY;
    w_align = (r_state == ST_STOP) && !r_sent && w_free && !NEWSLICE;
    w_done  = (r_state == ST_STOP) && r_sent && OVALID && OREADY && !NEWSLICE;
    w_load  = w_hacc || w_cacc || w_align;
    w_ve    = '0;
    w_vl    = '0;
    if (w_hacc) begin
      w_ve = {5'b0, HVE};
      w_vl = HVL;
    end else if (w_cacc) begin
      w_ve = CVE;
      w_vl = CVL;
    end else if (w_align) begin
      w_vl = align_len(r_pos);
      w_ve = VE_W'(1) << (w_vl - 5'd1);
    end
  end

  assign w_sum = {6'b0, r_bits} + {{(CNTW+1){1'b0}}, w_vl};

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_end  <= 1'b0;
      r_sent <= 1'b0;
      r_pos  <= '0;
      r_bits <= '0;
    end else if (NEWSLICE) begin
      r_end  <= 1'b0;
      r_sent <= 1'b0;
      r_pos  <= '0;
      r_bits <= '0;
    end else begin
      if (SLICEEND)    r_end <= 1'b1;
      else if (w_done) r_end <= 1'b0;
      if (w_align)     r_sent <= 1'b1;
      else if (w_done) r_sent <= 1'b0;
      if (w_load) begin
        r_pos  <= r_pos + w_vl[2:0];
        r_bits <= (|w_sum[CNTW+5:CNTW]) ? {CNTW{1'b1}} : w_sum[CNTW-1:0];
      end
    end
  end

  h264_stream_oreg #(.W(OREG_W)) u_oreg (
    .CLK     (CLK),
    .RESETN  (RESETN),
    .i_clr   (NEWSLICE),
    .i_load  (w_load),
    .i_data  ({w_vl, w_ve}),
    .i_ready (OREADY),
    .o_free  (w_free),
    .o_valid (OVALID),
    .o_data  (w_odata)
  );

  assign OVE  = w_odata[VE_W-1:0];
  assign OVL  = w_odata[OREG_W-1:VE_W];
  assign DONE = w_done;
  assign BITS = r_bits;
endmodule

// File: tb/tb_h264_stream_scheduler.sv
// tb/tb_h264_stream_scheduler.sv - scoreboard bench for h264_stream_scheduler
module tb_h264_stream_scheduler;
  logic        CLK = 1'b0, RESETN = 1'b0, NEWSLICE = 1'b0, SLICEEND = 1'b0;
  logic        HVALID = 1'b0, HLAST = 1'b0, CVALID = 1'b0, CLAST = 1'b0, OREADY = 1'b1;
  logic [19:0] HVE = '0;
  logic [4:0]  HVL = '0, CVL = '0;
  logic [24:0] CVE = '0;
  logic        HREADY, CREADY, OVALID, DONE;
  logic [24:0] OVE;
  logic [4:0]  OVL;
  logic [23:0] BITS;
  logic        h4, c4, ov4, d4;
  logic [24:0] ove4;
  logic [4:0]  ovl4;
  logic [3:0]  bits4;

  int n_chk = 0, n_err = 0, cyc = 0, done_cnt = 0;
  int t_h, t_c;
  logic [30:0] exp_q[$];
  logic [30:0] e_w;

  h264_stream_scheduler #(.CNTW(24)) u_dut (
    .CLK(CLK), .RESETN(RESETN), .NEWSLICE(NEWSLICE), .SLICEEND(SLICEEND),
    .HVALID(HVALID), .HREADY(HREADY), .HVE(HVE), .HVL(HVL), .HLAST(HLAST),
    .CVALID(CVALID), .CREADY(CREADY), .CVE(CVE), .CVL(CVL), .CLAST(CLAST),
    .OVALID(OVALID), .OREADY(OREADY), .OVE(OVE), .OVL(OVL), .DONE(DONE), .BITS(BITS)
  );

  h264_stream_scheduler #(.CNTW(4)) u_dut4 (
    .CLK(CLK), .RESETN(RESETN), .NEWSLICE(NEWSLICE), .SLICEEND(SLICEEND),
    .HVALID(HVALID), .HREADY(h4), .HVE(HVE), .HVL(HVL), .HLAST(HLAST),
    .CVALID(CVALID), .CREADY(c4), .CVE(CVE), .CVL(CVL), .CLAST(CLAST),
    .OVALID(ov4), .OREADY(OREADY), .OVE(ove4), .OVL(ovl4), .DONE(d4), .BITS(bits4)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  always @(negedge CLK) begin
    if (RESETN && OVALID && OREADY) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_out: got ove=%0h ovl=%0d done=%0b required no output", OVE, OVL, DONE);
      end else begin
        e_w = exp_q.pop_front();
        chk("out_word{done,vl,ve}", {1'b0, DONE, OVL, OVE}, {1'b0, e_w});
        if (DONE) done_cnt++;
      end
    end
  end

  task automatic send_hdr(input logic [19:0] ve, input logic [4:0] vl, input logic lst,
                          input logic push, output int acyc);
    int n;
    logic acc;
    n = 0; acc = 1'b0; acyc = -1;
    HVALID = 1'b1; HVE = ve; HVL = vl; HLAST = lst;
    while (!acc && n < 40) begin
      @(negedge CLK);
      if (HREADY) begin
        acc = 1'b1;
        acyc = cyc;
        if (push) exp_q.push_back({1'b0, vl, 5'b0, ve});
      end
      n++;
      @(posedge CLK); #1;
    end
    HVALID = 1'b0;
    if (!acc) begin
      n_chk++; n_err++;
      $display("FAIL hdr_accept: got no accept in 40 cycles required accept");
    end
  endtask

  task automatic send_cav(input logic [24:0] ve, input logic [4:0] vl, input logic lst,
                          output int acyc);
    int n;
    logic acc;
    n = 0; acc = 1'b0; acyc = -1;
    CVALID = 1'b1; CVE = ve; CVL = vl; CLAST = lst;
    while (!acc && n < 40) begin
      @(negedge CLK);
      if (CREADY) begin
        acc = 1'b1;
        acyc = cyc;
        exp_q.push_back({1'b0, vl, ve});
      end
      n++;
      @(posedge CLK); #1;
    end
    CVALID = 1'b0;
    if (!acc) begin
      n_chk++; n_err++;
      $display("FAIL cav_accept: got no accept in 40 cycles required accept");
    end
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 40) begin
      @(negedge CLK);
      n++;
    end
    @(negedge CLK);
    chk("done_count", done_cnt, target);
    @(posedge CLK); #1;
  endtask

  task automatic pulse_end(input logic ns);
    SLICEEND = 1'b1; NEWSLICE = ns;
    @(posedge CLK); #1;
    SLICEEND = 1'b0; NEWSLICE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_ovalid", OVALID, 0);
    chk("rst_hready", HREADY, 0);
    chk("rst_cready", CREADY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_bits", BITS, 0);
    chk("rst_ove_ovl", {OVL, OVE}, 0);
    chk("rst_bits4", bits4, 0);
    @(posedge CLK); #1;
    RESETN = 1'b1;
    @(posedge CLK); #1;

    // Header 5/L3 then CAVLC 1/L1 back to back
    send_hdr(20'h00005, 5'd3, 1'b1, 1'b1, t_h);
    send_cav(25'h1, 5'd1, 1'b1, t_c);
    chk("consecutive_accept", t_c - t_h, 1);
    @(negedge CLK);
    chk("bits_after_mb1", BITS, 4);
    @(posedge CLK); #1;

    // POS=4: zero-length header, 8-bit CAVLC, then 4-bit alignment word 0x08
    pulse_end(1'b0);
    send_hdr(20'h0, 5'd0, 1'b1, 1'b1, t_h);
    send_cav(25'hA5, 5'd8, 1'b1, t_c);
    exp_q.push_back({1'b1, 5'd4, 25'h08});
    wait_done(1);
    chk("bits_after_align4", BITS, 16);

    // POS=0 in IDLE: full byte 0x80/L8
    exp_q.push_back({1'b1, 5'd8, 25'h80});
    pulse_end(1'b0);
    wait_done(2);
    chk("bits_after_align8", BITS, 24);

    NEWSLICE = 1'b1;
    @(posedge CLK); #1;
    NEWSLICE = 1'b0;
    @(negedge CLK);
    chk("bits_after_newslice", BITS, 0);
    @(posedge CLK); #1;

    // Downstream stall with a different word waiting upstream
    OREADY = 1'b0;
    HVALID = 1'b1; HVE = 20'h12345; HVL = 5'd20; HLAST = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (HREADY) begin
        exp_q.push_back({1'b0, 5'd20, 5'b0, 20'h12345});
        break;
      end
      @(posedge CLK); #1;
    end
    @(posedge CLK); #1;
    HVE = 20'h00777; HVL = 5'd7; HLAST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("stall_ovalid", OVALID, 1);
      chk("stall_ove", OVE, 25'h12345);
      chk("stall_ovl", OVL, 20);
      chk("stall_hready", HREADY, 0);
      @(posedge CLK); #1;
    end
    OREADY = 1'b1;
    send_hdr(20'h00777, 5'd7, 1'b1, 1'b1, t_h);
    send_cav(25'h3, 5'd2, 1'b1, t_c);

    // CVALID while in HDR, then NEWSLICE+SLICEEND together
    CVALID = 1'b1; CVE = 25'h5; CVL = 5'd3; CLAST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("cvalid_in_hdr_stalled", CREADY, 0);
      @(posedge CLK); #1;
    end
    NEWSLICE = 1'b1; SLICEEND = 1'b1;
    @(negedge CLK);
    chk("cready_at_newslice", CREADY, 0);
    @(posedge CLK); #1;
    NEWSLICE = 1'b0; SLICEEND = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("cready_after_newslice", CREADY, 0);
      chk("ovalid_after_newslice", OVALID, 0);
      @(posedge CLK); #1;
    end
    CVALID = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("no_done_after_drop", done_cnt, 2);
    chk("bits_idle", BITS, 0);
    chk("hready_idle", HREADY, 0);
    @(posedge CLK); #1;

    // 8+8 bits: CNTW=4 saturates at 0xF, CNTW=24 reaches 16
    send_hdr(20'hFF, 5'd8, 1'b1, 1'b1, t_h);
    send_cav(25'h55, 5'd8, 1'b1, t_c);
    @(negedge CLK);
    chk("bits24_16", BITS, 16);
    chk("bits4_sat", bits4, 4'hF);
    @(posedge CLK); #1;

    // Reset in the middle of a held word
    OREADY = 1'b0;
    send_hdr(20'h1, 5'd1, 1'b0, 1'b0, t_h);
    @(negedge CLK);
    chk("held_ovalid", OVALID, 1);
    #2;
    RESETN = 1'b0;
    #1;
    chk("async_rst_ovalid", OVALID, 0);
    chk("async_rst_ove_ovl", {OVL, OVE}, 0);
    chk("async_rst_bits", BITS, 0);
    chk("async_rst_ovalid4", ov4, 0);
    @(posedge CLK); #1;
    RESETN = 1'b1;
    OREADY = 1'b1;
    repeat (6) @(negedge CLK);
    chk("queue_drained", exp_q.size(), 0);
    chk("final_done_count", done_cnt, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/h264_stream_scheduler.md
H264_STREAM_SCHEDULER -- requirements
Module: h264_stream_scheduler

Interface
REQ-001 SHALL have parameter CNTW, default 24, giving the width of the per-slice emitted-bit counter.
REQ-002 SHALL have port CLK, input, 1: the single clock; all sequential logic uses its rising edge.
REQ-003 SHALL have port RESETN, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port NEWSLICE, input, 1: synchronous slice restart pulse.
REQ-005 SHALL have port SLICEEND, input, 1: pulse requesting slice close (stop bit plus byte alignment).
REQ-006 SHALL have ports HVALID/HREADY, in/out, 1/1: header word handshake.
REQ-007 SHALL have ports HVE/HVL/HLAST, in, 20/5/1: header value, length and last-header-word-of-MB flag.
REQ-008 SHALL have ports CVALID/CREADY, in/out, 1/1: CAVLC word handshake.
REQ-009 SHALL have ports CVE/CVL/CLAST, in, 25/5/1: CAVLC value, length and last-coefficient-word-of-MB flag.
REQ-010 SHALL have ports OVALID/OREADY, out/in, 1/1: handshake toward the byte packer.
REQ-011 SHALL have ports OVE/OVL, out, 25/5: emitted value (right-justified) and length.
REQ-012 SHALL have port DONE, out, 1: one-cycle pulse when the alignment word is accepted downstream.
REQ-013 SHALL have port BITS, out, CNTW: bits accepted in the current slice, saturating at all-ones.

Function
REQ-014 SHALL run an FSM with states IDLE, HDR, COEF, STOP.
REQ-015 IDLE->HDR when HVALID=1; IDLE->STOP when the end-pending flag is set.
REQ-016 HDR: SHALL accept header words only; an accepted word with HLAST=1 moves to COEF.
REQ-017 COEF: SHALL accept CAVLC words only; an accepted word with CLAST=1 moves to STOP if end-pending, else to HDR.
REQ-018 STOP: SHALL load one alignment word; when it is accepted downstream, pulse DONE, clear end-pending and move to IDLE.
REQ-019 SLICEEND SHALL set the end-pending flag in any state, and the flag SHALL hold until it is consumed in STOP.
REQ-020 A single-entry output register SHALL hold OVE/OVL/OVALID; the register is free when OVALID=0 or OREADY=1.
REQ-021 HREADY SHALL be 1 only when state=HDR and the register is free; CREADY likewise for COEF.
REQ-022 An accepted input SHALL appear on OVALID the next cycle (latency 1); header values are zero-extended to 25 bits.
REQ-023 While OVALID=1 and OREADY=0, OVE/OVL SHALL be held stable.
REQ-024 A 3-bit bit-position POS SHALL update to (POS+VL) mod 8 on every word loaded into the output register.
REQ-025 The alignment word SHALL have L = 8-POS (L=8 when POS=0) and value 1<<(L-1); after it, POS=0.
REQ-026 BITS SHALL add VL for every word loaded into the output register and SHALL saturate rather than wrap.
REQ-027 A word with VL=0 SHALL be accepted and forwarded, leaving POS and BITS unchanged.
REQ-028 NEWSLICE SHALL clear state to IDLE and clear POS, BITS, end-pending, OVALID and DONE; it takes priority over all other events in the same cycle.
REQ-029 SLICEEND and NEWSLICE together SHALL resolve to NEWSLICE (the end request is dropped).
REQ-030 HVALID in COEF and CVALID in HDR SHALL be stalled and never dropped.

Reset
REQ-031 RESETN low SHALL immediately force state IDLE, POS=0, BITS=0, end-pending=0, OVALID=0, OVE=0, OVL=0 and DONE=0.
REQ-032 At reset, HREADY=0 and CREADY=0.
REQ-033 Reset asserted mid-transfer SHALL discard the held output word, with no partial emission after release.

Structure
REQ-034 The state enum and the constants ALIGN_BYTE=8 and VE_W=25 SHALL reside in the shared package h264_pkg.
REQ-035 The output register SHALL be the sub-module h264_stream_oreg (a one-entry VALID/READY register, width 30).

Verification
REQ-036 Header 0x00005/L3 (HLAST), CAVLC 0x1/L1 (CLAST), OREADY=1 -> outputs on consecutive cycles, POS=4, BITS=4.
REQ-037 With POS=4, pulse SLICEEND and complete the MB -> alignment word OVE=0x08, OVL=4, DONE for 1 cycle, BITS=+4.
REQ-038 With POS=0 at SLICEEND -> OVE=0x80, OVL=8.
REQ-039 OREADY=0 for 5 cycles with HVALID high -> OVE/OVL held constant and HREADY=0 after the first accept.
REQ-040 Issue CVALID in HDR, then NEWSLICE together with SLICEEND -> CAVLC is never accepted, state is IDLE, no DONE.
REQ-041 CNTW=4 with accepted lengths 8+8 -> BITS=0xF; RESETN pulsed low mid-word -> OVALID=0 in the same cycle.
